// File: rtl/ddr_sched_pkg.sv
// Shared types and address helper for the DDR read/write burst scheduler.
package ddr_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_START,
        S_WR_RUN,
        S_RD_START,
        S_RD_RUN
    } sched_state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

    function automatic logic [63:0] burst_addr(
        input logic [63:0] base,
        input logic [31:0] ptr,
        input logic [31:0] burst_bytes
    );
        return base + ({32'd0, ptr} * {32'd0, burst_bytes});
    endfunction

endpackage

// File: rtl/ddr_rw_scheduler_busy_monitor.sv
// Tracks the engine busy line after a begin pulse: start, finish, timeout.
module ddr_busy_monitor #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic launch,
    input  logic busy,
    output logic started,
    output logic done,
    output logic timeout
);

    localparam int TW = $clog2(TIMEOUT + 1) + 1;

    logic          busy_q;
    logic          wait_q;
    logic [TW-1:0] cnt_q;
    logic          active;
    logic [TW-1:0] elapsed;

    // The pulse cycle itself counts as the first waiting cycle.
    always_comb begin
        active  = launch | wait_q;
        elapsed = (launch ? '0 : cnt_q) + TW'(1);
        started = active & busy;
        timeout = active & ~busy & (elapsed >= TW'(TIMEOUT));
        done    = busy_q & ~busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            wait_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy;
            wait_q <= active & ~busy & ~timeout;
            cnt_q  <= active ? elapsed : '0;
        end
    end

endmodule

// File: rtl/ddr_rw_scheduler.sv
// Round-robin scheduler sharing one DDR burst engine between
// a write stream and a read stream over a circular region.
module ddr_rw_scheduler
    import ddr_sched_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                CNT_W          = 10,
    parameter int                BURST_LEN      = 32,
    parameter int                BYTES_PER_BEAT = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h0100_0000,
    parameter int                REGION_BURSTS  = 64,
    parameter int                WR_THRESH      = 32,
    parameter int                RD_THRESH      = 64,
    parameter int                START_TIMEOUT  = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             init_calib_complete,
    input  logic [CNT_W-1:0]                 wr_fifo_cnt,
    input  logic [CNT_W-1:0]                 rd_fifo_cnt,
    output logic                             wr_begin,
    output logic [ADDR_W-1:0]                wr_addr_begin,
    input  logic                             wr_data_busy,
    output logic                             rd_begin,
    output logic [ADDR_W-1:0]                rd_addr_begin,
    output logic [ADDR_W-1:0]                rd_addr_end,
    input  logic                             rd_data_busy,
    output logic [$clog2(REGION_BURSTS):0]   stored_bursts,
    output logic                             sched_err
);

    localparam int PW          = $clog2(REGION_BURSTS);
    localparam int SW          = PW + 1;
    localparam int BURST_BYTES = BURST_LEN * BYTES_PER_BEAT;
    localparam int END_OFS     = (BURST_LEN - 1) * BYTES_PER_BEAT;

    sched_state_t      state;
    grant_t            last_grant;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              wr_req;
    logic              rd_req;
    logic              grant_wr;
    logic              grant_rd;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic              wr_started;
    logic              wr_done;
    logic              wr_timeout;
    logic              rd_started;
    logic              rd_done;
    logic              rd_timeout;

    always_comb begin
        wr_req = init_calib_complete
               & (wr_fifo_cnt >= CNT_W'(WR_THRESH))
               & (stored_bursts < SW'(REGION_BURSTS));
        rd_req = init_calib_complete
               & (rd_fifo_cnt <= CNT_W'(RD_THRESH))
               & (stored_bursts != '0);
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        unique case (1'b1)
            (wr_req & rd_req): begin
                grant_wr = (last_grant == GRANT_RD);
                grant_rd = (last_grant == GRANT_WR);
            end
            (wr_req & ~rd_req): grant_wr = 1'b1;
            (rd_req & ~wr_req): grant_rd = 1'b1;
            default: ;
        endcase
        wr_addr_nxt = ADDR_W'(burst_addr(64'(BASE_ADDR), 32'(wr_ptr),
                                         32'(BURST_BYTES)));
        rd_addr_nxt = ADDR_W'(burst_addr(64'(BASE_ADDR), 32'(rd_ptr),
                                         32'(BURST_BYTES)));
    end

    ddr_busy_monitor #(.TIMEOUT(START_TIMEOUT)) u_wr_mon (
        .clk     (clk),
        .rst     (rst),
        .launch  (wr_begin),
        .busy    (wr_data_busy),
        .started (wr_started),
        .done    (wr_done),
        .timeout (wr_timeout)
    );

    ddr_busy_monitor #(.TIMEOUT(START_TIMEOUT)) u_rd_mon (
        .clk     (clk),
        .rst     (rst),
        .launch  (rd_begin),
        .busy    (rd_data_busy),
        .started (rd_started),
        .done    (rd_done),
        .timeout (rd_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            last_grant    <= GRANT_RD;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            stored_bursts <= '0;
            wr_begin      <= 1'b0;
            rd_begin      <= 1'b0;
            wr_addr_begin <= '0;
            rd_addr_begin <= '0;
            rd_addr_end   <= '0;
            sched_err     <= 1'b0;
        end else begin
            wr_begin <= 1'b0;
            rd_begin <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (grant_wr) begin
                        wr_begin      <= 1'b1;
                        wr_addr_begin <= wr_addr_nxt;
                        last_grant    <= GRANT_WR;
                        state         <= S_WR_START;
                    end else if (grant_rd) begin
                        rd_begin      <= 1'b1;
                        rd_addr_begin <= rd_addr_nxt;
                        rd_addr_end   <= rd_addr_nxt + ADDR_W'(END_OFS);
                        last_grant    <= GRANT_RD;
                        state         <= S_RD_START;
                    end
                end
                S_WR_START: begin
                    if (wr_started) begin
                        state <= S_WR_RUN;
                    end else if (wr_timeout) begin
                        sched_err <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_WR_RUN: begin
                    if (wr_done) begin
                        wr_ptr        <= wr_ptr + PW'(1);
                        stored_bursts <= stored_bursts + SW'(1);
                        state         <= S_IDLE;
                    end
                end
                S_RD_START: begin
                    if (rd_started) begin
                        state <= S_RD_RUN;
                    end else if (rd_timeout) begin
                        sched_err <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_RD_RUN: begin
                    if (rd_done) begin
                        rd_ptr        <= rd_ptr + PW'(1);
                        stored_bursts <= stored_bursts - SW'(1);
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rw_scheduler.sv
// Directed self-checking bench for ddr_rw_scheduler.
module tb_ddr_rw_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_calib_complete;
    logic [9:0]  wr_fifo_cnt;
    logic [9:0]  rd_fifo_cnt;
    logic        wr_begin;
    logic [31:0] wr_addr_begin;
    logic        wr_data_busy;
    logic        rd_begin;
    logic [31:0] rd_addr_begin;
    logic [31:0] rd_addr_end;
    logic        rd_data_busy;
    logic [6:0]  stored_bursts;
    logic        sched_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr_rw_scheduler dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .wr_fifo_cnt         (wr_fifo_cnt),
        .rd_fifo_cnt         (rd_fifo_cnt),
        .wr_begin            (wr_begin),
        .wr_addr_begin       (wr_addr_begin),
        .wr_data_busy        (wr_data_busy),
        .rd_begin            (rd_begin),
        .rd_addr_begin       (rd_addr_begin),
        .rd_addr_end         (rd_addr_end),
        .rd_data_busy        (rd_data_busy),
        .stored_bursts       (stored_bursts),
        .sched_err           (sched_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the next begin pulse, check it, then play one engine burst.
    task automatic burst(input bit exp_wr, input logic [31:0] exp_addr,
                         input int exp_stored);
        int n = 0;
        while (!(wr_begin | rd_begin) && n < 20) begin
            tick();
            n++;
        end
        chk("begin_seen", 64'(wr_begin | rd_begin), 64'd1);
        chk("grant_side", 64'(wr_begin), 64'(exp_wr));
        chk("begin_excl", 64'(wr_begin & rd_begin), 64'd0);
        if (exp_wr) begin
            chk("wr_addr", 64'(wr_addr_begin), 64'(exp_addr));
            wr_data_busy = 1'b1;
        end else begin
            chk("rd_addr", 64'(rd_addr_begin), 64'(exp_addr));
            chk("rd_end", 64'(rd_addr_end), 64'(exp_addr + 32'h1F0));
            rd_data_busy = 1'b1;
        end
        repeat (3) tick();
        wr_data_busy = 1'b0;
        rd_data_busy = 1'b0;
        tick();
        chk("stored", 64'(stored_bursts), 64'(exp_stored));
    endtask

    initial begin
        bit seen;
        int n;

        rst                 = 1'b1;
        init_calib_complete = 1'b0;
        wr_fifo_cnt         = '0;
        rd_fifo_cnt         = 10'd1000;
        wr_data_busy        = 1'b0;
        rd_data_busy        = 1'b0;
        repeat (2) tick();
        chk("rst_wr_begin", 64'(wr_begin), 64'd0);
        chk("rst_rd_begin", 64'(rd_begin), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr_begin), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr_begin), 64'd0);
        chk("rst_rd_end", 64'(rd_addr_end), 64'd0);
        chk("rst_stored", 64'(stored_bursts), 64'd0);
        chk("rst_err", 64'(sched_err), 64'd0);
        rst = 1'b0;
        tick();

        // calibration gates the first write
        wr_fifo_cnt = 10'd40;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= wr_begin;
        end
        chk("no_calib_wr", 64'(seen), 64'd0);
        init_calib_complete = 1'b1;
        tick();
        chk("first_wr_pulse", 64'(wr_begin), 64'd1);
        chk("first_wr_addr", 64'(wr_addr_begin), 64'h0100_0000);
        tick();
        chk("pulse_one_cycle", 64'(wr_begin), 64'd0);
        wr_data_busy = 1'b1;
        repeat (5) tick();
        wr_data_busy = 1'b0;
        tick();
        chk("first_stored", 64'(stored_bursts), 64'd1);

        // both sides requesting: grants alternate
        rd_fifo_cnt = 10'd0;
        burst(1'b0, 32'h0100_0000, 0);
        burst(1'b1, 32'h0100_0200, 1);
        burst(1'b0, 32'h0100_0200, 0);
        burst(1'b1, 32'h0100_0400, 1);

        // reset during a read burst
        wr_fifo_cnt = 10'd0;
        n = 0;
        while (!rd_begin && n < 20) begin
            tick();
            n++;
        end
        chk("rd_seen", 64'(rd_begin), 64'd1);
        chk("rd_addr_pre_rst", 64'(rd_addr_begin), 64'h0100_0400);
        rd_data_busy = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_rd_begin", 64'(rd_begin), 64'd0);
        chk("mid_rst_wr_begin", 64'(wr_begin), 64'd0);
        chk("mid_rst_rd_addr", 64'(rd_addr_begin), 64'd0);
        chk("mid_rst_rd_end", 64'(rd_addr_end), 64'd0);
        chk("mid_rst_wr_addr", 64'(wr_addr_begin), 64'd0);
        chk("mid_rst_stored", 64'(stored_bursts), 64'd0);
        rst = 1'b0;
        tick();
        rd_data_busy = 1'b0;
        repeat (2) tick();
        chk("idle_busy_fall", 64'(stored_bursts), 64'd0);

        // empty region: never read
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            seen |= rd_begin;
        end
        chk("empty_no_rd", 64'(seen), 64'd0);

        // fill the whole region, wrapping the write pointer
        rd_fifo_cnt = 10'd1000;
        wr_fifo_cnt = 10'd40;
        for (int i = 0; i < 64; i++)
            burst(1'b1, 32'h0100_0000 + 32'(i) * 32'h200, i + 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= wr_begin | rd_begin;
        end
        chk("full_no_wr", 64'(seen), 64'd0);
        chk("full_stored", 64'(stored_bursts), 64'd64);
        rd_fifo_cnt = 10'd0;
        burst(1'b0, 32'h0100_0000, 63);
        burst(1'b1, 32'h0100_0000, 64);
        rd_fifo_cnt = 10'd1000;
        tick();

        // start timeout on a write
        rd_fifo_cnt = 10'd0;
        burst(1'b0, 32'h0100_0200, 63);
        rd_fifo_cnt = 10'd1000;
        n = 0;
        while (!wr_begin && n < 20) begin
            tick();
            n++;
        end
        chk("to_wr_seen", 64'(wr_begin), 64'd1);
        chk("to_wr_addr", 64'(wr_addr_begin), 64'h0100_0200);
        n = 0;
        while (!sched_err && n < 400) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'd255);
        chk("timeout_stored", 64'(stored_bursts), 64'd63);
        tick();
        chk("retry_pulse", 64'(wr_begin), 64'd1);
        chk("retry_addr", 64'(wr_addr_begin), 64'h0100_0200);
        burst(1'b1, 32'h0100_0200, 64);
        chk("err_sticky", 64'(sched_err), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_rw_scheduler.md
Name: ddr_rw_scheduler

Overview:
- Single-clock scheduler that shares one AXI DDR3 burst engine between a write stream and a read stream.
- Monitors the write-side FIFO fill and read-side FIFO fill, and decides which burst to issue next using round-robin.
- Issues wr_begin/rd_begin pulses with burst addresses, then waits for the engine busy handshake to complete.
- Manages a circular DDR region, tracking stored bursts so reads never overtake writes and writes never overwrite unread data.

Parameters:
ADDR_W, 32, DDR byte-address width
CNT_W, 10, width of FIFO fill-count inputs
BURST_LEN, 32, beats per burst
BYTES_PER_BEAT, 16, bytes per AXI beat
BASE_ADDR, 32'h0100_0000, region start (burst-aligned)
REGION_BURSTS, 64, region size in bursts (power of 2, ≥2)
WR_THRESH, 32, write FIFO words needed to request a write burst
RD_THRESH, 64, read FIFO fill at or below which a read burst is requested
START_TIMEOUT, 255, cycles allowed for engine busy to assert after a begin pulse

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
init_calib_complete  in  1  DDR calibration done; no issue while low
wr_fifo_cnt  in  CNT_W  words waiting in write FIFO
rd_fifo_cnt  in  CNT_W  words in read FIFO
wr_begin  out  1  one-cycle write-burst start pulse
wr_addr_begin  out  ADDR_W  write burst start address, valid with wr_begin
wr_data_busy  in  1  engine write burst in progress
rd_begin  out  1  one-cycle read-burst start pulse
rd_addr_begin  out  ADDR_W  read burst start address
rd_addr_end  out  ADDR_W  rd_addr_begin + (BURST_LEN-1)*BYTES_PER_BEAT
rd_data_busy  in  1  engine read burst in progress
stored_bursts  out  log2(REGION_BURSTS)+1  bursts written but not yet read
sched_err  out  1  sticky; set on start timeout

Behaviour:
- Reset: all outputs 0; FSM in IDLE; wr_ptr = rd_ptr = 0; stored_bursts = 0; last_grant = RD, so the first tie goes to write.
- BURST_BYTES = BURST_LEN*BYTES_PER_BEAT.
- Address calculation:
  - wr_addr_begin = BASE_ADDR + wr_ptr*BURST_BYTES.
  - rd_addr_begin = BASE_ADDR + rd_ptr*BURST_BYTES.
  - Pointers are log2(REGION_BURSTS) bits and wrap REGION_BURSTS-1 → 0.
- Request conditions:
  - wr_req = init_calib_complete & (wr_fifo_cnt ≥ WR_THRESH) & (stored_bursts < REGION_BURSTS).
  - rd_req = init_calib_complete & (rd_fifo_cnt ≤ RD_THRESH) & (stored_bursts > 0).
- FSM states: IDLE, WR_START, WR_RUN, RD_START, RD_RUN.
- IDLE:
  - If both requests are active, grant the side opposite last_grant; otherwise grant the single requester.
  - A grant registers the address and asserts the begin pulse on the next cycle (latency 1 from request to pulse).
  - State moves to WR_START or RD_START together with the pulse.
  - last_grant updates on grant.
- WR_START: wait for wr_data_busy=1 → WR_RUN.
  - A timeout counter starts at the pulse.
  - If START_TIMEOUT cycles pass without busy: set sched_err, return to IDLE, and leave pointers/count unchanged (the burst is abandoned).
- WR_RUN: on the wr_data_busy falling edge (registered previous-cycle value 1, current 0):
  - wr_ptr += 1 (wrap), stored_bursts += 1.
  - Return to IDLE; the next grant is possible in the following cycle.
- RD_START / RD_RUN: symmetric using rd_data_busy. Completion does rd_ptr += 1 and stored_bursts -= 1.
- Only one burst is outstanding at any time; begin pulses are never asserted in the same cycle.
- Address outputs hold their values between pulses.
- init_calib_complete falling mid-burst: the current burst completes normally; no new grants are made.
- Busy asserted while in IDLE: ignored; no counter change.
- Full condition (stored_bursts == REGION_BURSTS) suppresses wr_req. Empty condition (stored_bursts == 0) suppresses rd_req.
- rst mid-burst: immediate return to reset state. The engine is responsible for abandoning its own transfer.
- sched_err is cleared only by rst.

Decomposition:
- Shared package ddr_sched_pkg holds:
  - FSM state encoding;
  - grant enum (GRANT_WR, GRANT_RD);
  - function burst_addr(base, ptr, burst_bytes).
- One natural sub-module: ddr_busy_monitor, instantiated twice. It takes begin and busy and outputs started, done (falling edge) and timeout. It contains the timeout counter and the edge detector.

Test Plan:
- Calibration low, wr_fifo_cnt=40 → no wr_begin. Raise calib → wr_begin one cycle later with wr_addr_begin=0x0100_0000; busy high 5 cycles then low → stored_bursts=1.
- wr_fifo_cnt=40 and rd_fifo_cnt=0 constant, stored_bursts=1 → grants alternate W,R,W,R. Second write address=0x0100_0200; first read begin=0x0100_0000, end=0x0100_01F0.
- 64 writes without reads → wr_addr wraps through 0x0100_7E00. stored_bursts=64, wr_req blocked. One read → next write at 0x0100_0000.
- stored_bursts=0, rd_fifo_cnt=0 → no rd_begin ever.
- wr_begin issued, wr_data_busy never asserts → after 255 cycles sched_err=1, FSM back in IDLE, stored_bursts unchanged. Next request is issued to the same address.
- rst asserted during RD_RUN → next cycle all outputs 0 and pointers 0. A rd_data_busy fall afterwards does not change stored_bursts.
